uart_tx_periph: RTL and testbench

- Memory-mapped UART transmitter peripheral that responds on the CPU data-memory bus (rd/wr/addr/wdata/rdata) in the MEM stage.
- CPU stores bytes into a 4-entry TX FIFO; an 8N1 serializer shifts them out on UART_TX.
- Sticky status flags plus a maskable interrupt (irqout) feed the CPU's IRQ input.

---
 rtl/uart_tx_periph.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter on the CPU data-memory bus.
// Register map (byte addresses):
//   BASE_ADDR+0 TXDATA  write pushes wdata[7:0] into the TX FIFO, reads 0
//   BASE_ADDR+4 STATUS  {parity_present, overflow, tx_done, empty, full, busy};
//                       tx_done (bit3) and overflow (bit4) are write-1-to-clear
//   BASE_ADDR+8 CTRL    bit0 = irq_en
// The serializer emits 8N1 frames, LSB first, BAUD_DIV clocks per bit.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit (8E1) and makes STATUS bit5 read 1.
`timescale 1ns/1ps

module uart_tx_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0018,
  parameter int          BAUD_DIV   = 434,  // clocks per bit, >= 2
  parameter int          FIFO_DEPTH = 4     // power of two, >= 2
) (
  input  logic        clk,
  input  logic        reset,    // asynchronous, active low
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        UART_TX,
  output logic        irqout
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
`else
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic sel_txdata;
  logic sel_status;
  logic sel_ctrl;
  logic push_req;
  logic push_ok;
  logic push_drop;
  logic status_wr;
  logic ctrl_wr;

  assign sel_txdata = (addr == BASE_ADDR);
  assign sel_status = (addr == BASE_ADDR + 32'd4);
  assign sel_ctrl   = (addr == BASE_ADDR + 32'd8);

  // Only the low byte of TXDATA and a few control bits are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  assign fifo_full  = (count_reg == COUNT_FULL);
  assign fifo_empty = (count_reg == '0);

  // Fullness uses the count before any same-cycle pop, so a push that lands
  // while full is dropped even if the serializer frees a slot on that edge.
  assign push_req  = wr & sel_txdata;
  assign push_ok   = push_req & ~fifo_full;
  assign push_drop = push_req & fifo_full;
  assign status_wr = wr & sel_status;
  assign ctrl_wr   = wr & sel_ctrl;

  // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + PW'(push_ok);
    rd_ptr_next = rd_ptr_reg + PW'(pop);
    count_next  = count_reg + CW'(push_ok) - CW'(pop);
  end

  // FIFO bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // FIFO storage write port; storage needs no reset because count gates it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= wdata[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg;
  logic          shift_en;
  logic          frame_end;
  logic          tx_reg, tx_next;
  logic          baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic          parity_reg, parity_next;
`endif

  assign baud_wrap = (baud_reg == BAUD_LAST);

  // Next-state, counters, FIFO pop and the value the line takes after the edge.
  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    pop         = 1'b0;
    shift_en    = 1'b0;
    frame_end   = 1'b0;
    tx_next     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_START;
          baud_next  = '0;
          bit_next   = '0;
`ifdef UART_TX_PARITY_EN
          parity_next = 1'b0;
`endif
        end
      end

      ST_START: begin
        if (baud_wrap) begin
          baud_next  = '0;
          state_next = ST_DATA;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end

      ST_DATA: begin
        if (baud_wrap) begin
          baud_next = '0;
          shift_en  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_next = parity_reg ^ shift_reg[0];
`endif
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_wrap) begin
          baud_next  = '0;
          state_next = ST_STOP;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
`endif

      ST_STOP: begin
        if (baud_wrap) begin
          baud_next = '0;
          frame_end = 1'b1;
          // Chain straight into the next start bit so queued frames are
          // contiguous on the line.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_START;
            bit_next   = '0;
`ifdef UART_TX_PARITY_EN
            parity_next = 1'b0;
`endif
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        baud_next  = '0;
        bit_next   = '0;
      end
    endcase

    // Line level registered from next-cycle state so UART_TX never glitches.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_en ? shift_reg[1] : shift_reg[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_next;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  // FSM state, counters and the registered serial output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // Shift register doubles as the FIFO's registered read port.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_reg <= fifo_mem[rd_ptr_reg];
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags, control and interrupt
  // ---------------------------------------------------------------------------
  logic tx_done_reg;
  logic overflow_reg;
  logic irq_en_reg;
  logic irq_reg;
  logic busy;

  assign busy = (state_reg != ST_IDLE);

  // Sticky flags: a hardware set on the same edge as a W1C clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_done_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      irq_en_reg   <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      if (frame_end) begin
        tx_done_reg <= 1'b1;
      end else if (status_wr && wdata[3]) begin
        tx_done_reg <= 1'b0;
      end

      if (push_drop) begin
        overflow_reg <= 1'b1;
      end else if (status_wr && wdata[4]) begin
        overflow_reg <= 1'b0;
      end

      if (ctrl_wr) begin
        irq_en_reg <= wdata[0];
      end

      irq_reg <= irq_en_reg & tx_done_reg;
    end
  end

  // Side-effect-free combinational read mux.
  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if (sel_status) begin
        rdata = {26'b0, PARITY_PRESENT, overflow_reg, tx_done_reg,
                 fifo_empty, fifo_full, busy};
      end else if (sel_ctrl) begin
        rdata = {31'b0, irq_en_reg};
      end
    end
  end

  assign UART_TX = tx_reg;
  assign irqout  = irq_reg;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed testbench for uart_tx_periph with BAUD_DIV=4.
// A negedge recorder captures UART_TX every cycle; frames are compared
// against waveforms built from the byte values.
`timescale 1ns/1ps

module tb_uart_tx_periph;

  localparam int          BD   = 4;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STA  = BASE + 32'd4;
  localparam logic [31:0] CTL  = BASE + 32'd8;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
  localparam logic [31:0] PB    = 32'h20;
`else
  localparam int          NBITS = 10;
  localparam logic [31:0] PB    = 32'h0;
`endif
  localparam int FRAME = NBITS * BD;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        UART_TX;
  logic        irqout;

  uart_tx_periph #(
    .BASE_ADDR (BASE),
    .BAUD_DIV  (BD),
    .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .UART_TX(UART_TX),
    .irqout (irqout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Line recorder: wave[i] holds UART_TX in the cycle after the i-th edge
  // following the point where rec_on was raised.
  logic wave [0:2047];
  int   rec_idx;
  bit   rec_on;

  always @(negedge clk) begin
    if (rec_on) begin
      if (rec_idx < 2048) wave[rec_idx] = UART_TX;
      rec_idx++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    step();
    wr    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd   = 1'b1;
    addr = a;
    #1;
    check(tag, {32'h0, rdata}, {32'h0, exp});
    rd   = 1'b0;
    addr = 32'h0;
  endtask

  function automatic logic [63:0] exp_wave(input logic [7:0] b);
    logic [10:0] bits;
    logic [63:0] w;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, 1'b1, b, 1'b0};
`endif
    w = '0;
    for (int j = 0; j < FRAME; j++) w[j] = bits[j / BD];
    return w;
  endfunction

  task automatic check_frames(input string pfx, input int start, input int n,
                              input logic [63:0] bytes);
    logic [63:0] obs;
    for (int f = 0; f < n; f++) begin
      obs = '0;
      for (int j = 0; j < FRAME; j++) obs[j] = wave[start + f * FRAME + j];
      check($sformatf("%s_frame%0d", pfx, f), obs, exp_wave(bytes[8*f +: 8]));
    end
  endtask

  function automatic int count_zeros(input int start, input int len);
    int z = 0;
    for (int i = start; i < start + len; i++) if (wave[i] !== 1'b1) z++;
    return z;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    rec_on = 1'b0; rec_idx = 0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", UART_TX, 1);
    check("rst_irq", irqout, 0);
    check_reg("rst_status", STA, 32'h4 | PB);
    reset = 1'b1;
    step(); step();
    check("idle_tx", UART_TX, 1);
    check("idle_irq", irqout, 0);
    check_reg("idle_status", STA, 32'h4 | PB);
    check_reg("idle_ctrl", CTL, 32'h0);
    check_reg("txdata_reads_zero", TXD, 32'h0);

    // Single byte 0xA5 written at edge k
    rec_idx = 0; rec_on = 1'b1;
    bus_write(TXD, 32'hA5);
    check("sb_tx_at_k", UART_TX, 1);
    check_reg("sb_status_k", STA, 32'h0 | PB);
    step();
    check("sb_start_bit", UART_TX, 0);
    check_reg("sb_status_busy", STA, 32'h5 | PB);
    repeat (FRAME - 1) step();
    check_reg("sb_done_not_early", STA, 32'h5 | PB);
    step();
    check_reg("sb_done", STA, 32'hC | PB);
    check("sb_irq_masked", irqout, 0);
    rec_on = 1'b0;
    check_frames("sb", 2, 1, 64'hA5);

    bus_write(STA, 32'h8);
    check_reg("w1c_done", STA, 32'h4 | PB);

    // Back-to-back: five writes, then a sixth while full
    rec_idx = 0; rec_on = 1'b1;
    bus_write(TXD, 32'h11);
    bus_write(TXD, 32'h22);
    bus_write(TXD, 32'h33);
    bus_write(TXD, 32'h44);
    bus_write(TXD, 32'h55);
    check_reg("b2b_full", STA, 32'h3 | PB);
    bus_write(TXD, 32'h66);
    check_reg("b2b_overflow", STA, 32'h13 | PB);
    repeat (5 * FRAME - 4) step();
    check_reg("b2b_end", STA, 32'h1C | PB);
    repeat (50) step();
    rec_on = 1'b0;
    check_frames("b2b", 2, 5, 64'h0000_0055_4433_2211);
    check("b2b_no_6th", count_zeros(2 + 5 * FRAME, 50), 0);
    bus_write(STA, 32'h18);
    check_reg("b2b_clear", STA, 32'h4 | PB);

    // Interrupt
    bus_write(CTL, 32'h1);
    check_reg("ctrl_rd", CTL, 32'h1);
    check("irq_idle", irqout, 0);
    bus_write(TXD, 32'h3C);
    repeat (FRAME) step();
    check("irq_before_done", irqout, 0);
    step();
    check_reg("irq_done_flag", STA, 32'hC | PB);
    check("irq_lag", irqout, 0);
    step();
    check("irq_set", irqout, 1);
    bus_write(STA, 32'h8);
    check_reg("irq_w1c_status", STA, 32'h4 | PB);
    check("irq_hold", irqout, 1);
    step();
    check("irq_clr", irqout, 0);

    // W1C on the same edge the frame ends: the set wins
    bus_write(TXD, 32'h5A);
    repeat (FRAME) step();
    bus_write(STA, 32'h8);
    check_reg("w1c_race", STA, 32'hC | PB);
    step();
    check("irq_race", irqout, 1);
    bus_write(CTL, 32'h0);
    check("irq_dis_lag", irqout, 1);
    step();
    check("irq_dis", irqout, 0);
    bus_write(STA, 32'h8);

    // Reset during data bit 3 of 0xFF with two bytes queued
    bus_write(TXD, 32'hFF);
    bus_write(TXD, 32'h12);
    bus_write(TXD, 32'h34);
    repeat (16) step();
    check_reg("mid_busy", STA, 32'h1 | PB);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_tx", UART_TX, 1);
    check("mid_rst_irq", irqout, 0);
    check_reg("mid_rst_status", STA, 32'h4 | PB);
    step(); step();
    reset = 1'b1;
    rec_idx = 0; rec_on = 1'b1;
    repeat (60) step();
    rec_on = 1'b0;
    check("mid_no_frames", count_zeros(0, 60), 0);
    check_reg("mid_after", STA, 32'h4 | PB);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 has odd weight (parity 1), 0x03 even weight (parity 0)
    rec_idx = 0; rec_on = 1'b1;
    bus_write(TXD, 32'h07);
    bus_write(TXD, 32'h03);
    repeat (2 * FRAME) step();
    rec_on = 1'b0;
    check_frames("par", 2, 2, 64'h0307);
    check("par_bit_07", wave[2 + 9 * BD + 1], 1);
    check("par_bit_03", wave[2 + FRAME + 9 * BD + 1], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
